// File: rtl/led_frame_buffer.sv
// led_frame_buffer: double-buffered 8-row pixel store for an LED matrix scanner.
// A producer fills the back bank over a valid/ready port and commits it with
// wr_last; the banks swap only on the scanner's frame_start pulse.
// Optional feature macro: LED_FB_COPY_EN -- at each swap the new back bank is
// preloaded with the new front bank so the producer may send only changed rows.
module led_frame_buffer #(
   parameter int unsigned COLS = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_valid,
   output logic            wr_ready,
   input  logic [2:0]      wr_row,
   input  logic [COLS-1:0] wr_data,
   input  logic            wr_last,
   input  logic [2:0]      rd_row,
   output logic [COLS-1:0] rd_data,
   input  logic            frame_start,
   output logic            swap_pending,
   output logic [7:0]      frame_count
);

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic            bank_sel_q, bank_sel_d;
   logic [7:0]      frame_count_q, frame_count_d;
   logic [COLS-1:0] rd_data_q, rd_data_d;
   logic [COLS-1:0] bank0_q [8];
   logic [COLS-1:0] bank1_q [8];
   logic            accept;
   logic            swap;

   assign wr_ready     = (state_q == ST_FILL);
   assign swap_pending = (state_q == ST_WAIT);
   assign frame_count  = frame_count_q;
   assign rd_data      = rd_data_q;

   // Next-state logic: accept beats while filling, swap on frame_start while waiting.
   always_comb begin
      state_d       = state_q;
      accept        = 1'b0;
      swap          = 1'b0;
      case (state_q)
         ST_FILL: begin
            if (wr_valid) begin
               accept = 1'b1;
               if (wr_last) state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (frame_start) begin
               swap    = 1'b1;
               state_d = ST_FILL;
            end
         end
         default: state_d = ST_FILL;
      endcase
      bank_sel_d    = bank_sel_q ^ swap;
      frame_count_d = swap ? frame_count_q + 8'd1 : frame_count_q;
   end

   // Read mux uses the post-swap bank select so the new frame shows right after the swap edge.
   always_comb begin
      rd_data_d = bank_sel_d ? bank1_q[rd_row] : bank0_q[rd_row];
   end

   // Control and read-data registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_FILL;
         bank_sel_q    <= 1'b0;
         frame_count_q <= '0;
         rd_data_q     <= '0;
      end else begin
         state_q       <= state_d;
         bank_sel_q    <= bank_sel_d;
         frame_count_q <= frame_count_d;
         rd_data_q     <= rd_data_d;
      end
   end

   // Bank storage: producer writes land in the back bank (bank1 when bank_sel is 0).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned r = 0; r < 8; r++) begin
            bank0_q[r] <= '0;
            bank1_q[r] <= '0;
         end
      end else begin
         if (accept) begin
            if (bank_sel_q) bank0_q[wr_row] <= wr_data;
            else            bank1_q[wr_row] <= wr_data;
         end
`ifdef LED_FB_COPY_EN
         // Accept and swap are mutually exclusive (FILL vs WAIT), so no write collides with the copy.
         if (swap) begin
            if (bank_sel_q) bank1_q <= bank0_q;
            else            bank0_q <= bank1_q;
         end
`endif
      end
   end

endmodule

// File: doc/led_frame_buffer.md
# led_frame_buffer

Double-buffered 8-row pixel store that sits directly upstream of the LED matrix row scanner. A producer writes the row bitmaps of the next frame into the back bank over a valid/ready port. The scanner reads the front bank by row index. Banks swap only at the scanner's frame boundary, so a partially written frame is never displayed.

## Interface
Parameters:
- COLS, default 8: pixels per row; width of all row data buses.

Ports:
- clk, in, 1: system clock; all logic on posedge.
- rst, in, 1: reset, asynchronous and active-high.
- wr_valid, in, 1: producer has a row beat.
- wr_ready, out, 1: block accepts a beat this cycle. A beat is accepted when wr_valid && wr_ready.
- wr_row, in, 3: target row 0..7 in the back bank.
- wr_data, in, COLS: row bitmap. Bit c drives column c; 1 = lit.
- wr_last, in, 1: final beat of the frame; commits the back bank for swap.
- rd_row, in, 3: row the scanner is displaying.
- rd_data, out, COLS: front-bank row rd_row, registered.
- frame_start, in, 1: single-cycle pulse from the scanner when its row index wraps to 0.
- swap_pending, out, 1: a committed frame is waiting for frame_start.
- frame_count, out, 8: number of swaps performed; wraps 255 -> 0.

## Operation
- Storage: two banks of 8 x COLS registers. bank_sel selects the front bank; the other bank is the back bank.
- Write port:
  - wr_ready = !swap_pending (combinational).
  - An accepted beat writes wr_data into back[wr_row].
  - Rows may arrive in any order and may repeat. A later write to the same row overwrites the earlier one.
  - An accepted beat with wr_last set sets swap_pending at the same edge as the data write.
- Swap: at a clock edge where frame_start = 1 and swap_pending is already 1:
  - bank_sel toggles.
  - swap_pending clears.
  - frame_count increments.
  - frame_start while swap_pending = 0 has no effect; the front bank keeps displaying.
- Read port: rd_data <= front[rd_row] every cycle.
- States (implicit):
  - FILL (swap_pending = 0): writes accepted.
  - WAIT (swap_pending = 1): writes stalled.
  - FILL -> WAIT on an accepted wr_last beat.
  - WAIT -> FILL on frame_start.
- Reset values:
  - rd_data = 0, swap_pending = 0, wr_ready = 1, frame_count = 0.
  - bank_sel = 0; all bank registers cleared to 0.
- Reset mid-operation: partially written rows and a pending swap are discarded. The display shows blank (all 0) until the first committed frame swaps in.

## Timing
- Read latency: 1 cycle from rd_row to rd_data. The scanner holds rd_row for thousands of cycles, so this latency is not visible.
- Write to display: the frame becomes visible 1 cycle after the first frame_start edge that follows the wr_last acceptance edge.
- Accepted wr_last in the same cycle as frame_start:
  - No swap at that edge, because swap_pending was 0 before it.
  - swap_pending = 1 afterwards; the swap happens at the next frame_start.
- Stall release: after a swap edge, wr_ready = 1 from the next cycle.
- rd_data in the cycle after a swap shows new-bank data for the current rd_row.
- Throughput: 1 beat per cycle while in FILL; a full frame takes 8 cycles minimum.

## Configuration
- LED_FB_COPY_EN defined:
  - At the swap edge, the new back bank is loaded with the contents of the new front bank.
  - The producer can then send only the changed rows, followed by a wr_last beat.
- LED_FB_COPY_EN undefined:
  - The new back bank keeps its old contents, i.e. the frame displayed before the swap.
  - The producer must rewrite every row it expects to change relative to that older frame.

## Test plan
- Reset, then rd_row = 0..7 -> rd_data = 0 for every row; wr_ready = 1; frame_count = 0.
- Write rows 0..7 with 0x60, 0x80, 0x80, 0x66, 0x09, 0x09, 0x06, 0x01 (last beat wr_last = 1) -> swap_pending = 1 and wr_ready = 0. After a frame_start pulse, rd_row = 3 gives rd_data = 0x66, frame_count = 1, wr_ready = 1.
- Hold wr_valid = 1 while swap_pending = 1 -> no beat is accepted and the back-bank contents are unchanged. Pulse frame_start with no pending frame -> front data and frame_count unchanged.
- Accepted wr_last coincident with frame_start -> no swap at that edge, swap_pending = 1. The next frame_start swaps, frame_count +1.
- With LED_FB_COPY_EN: after the first frame is displayed, write only row 2 = 0xFF with wr_last, then swap -> row 2 = 0xFF and the other rows keep their first-frame values. Without the macro -> the other rows read 0.
- Assert rst while swap_pending = 1 after 5 of 8 rows are written -> all outputs return to reset values. 255 further swaps after a count of 1 -> frame_count wraps to 0.
